// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: four-LED pattern sequencer.
// Supports walk, bounce, count and blink modes. A prescaler paces the
// pattern while running, and single-step pulses advance it while paused.
module led_seq_ctrl #(
    parameter int unsigned DIV = 3_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] mode_sel,
    input  logic       mode_load,
    input  logic       run,
    input  logic       step,
    output logic [3:0] leds,
    output logic       tick,
    output logic [1:0] mode
);

    localparam int unsigned      PW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PMAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        M_WALK   = 2'd0,
        M_BOUNCE = 2'd1,
        M_COUNT  = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    mode_t         mode_q, mode_nxt;
    dir_t          dir_q, dir_nxt;
    logic [PW-1:0] pcnt, pcnt_nxt;
    logic [3:0]    leds_nxt;
    logic          tick_nxt;
    logic          wrap_c;
    logic          adv_c;

    assign mode = mode_q;

    // First pattern shown after a mode is (re)loaded.
    function automatic logic [3:0] init_leds(input mode_t m);
        logic [3:0] r;
        unique case (m)
            M_WALK:   r = 4'b0001;
            M_BOUNCE: r = 4'b0001;
            M_COUNT:  r = 4'b0000;
            M_BLINK:  r = 4'b1111;
        endcase
        return r;
    endfunction

    // Next-state: prescaler, advance decode, mode load and pattern update.
    always_comb begin
        mode_nxt = mode_q;
        dir_nxt  = dir_q;
        pcnt_nxt = pcnt;
        leds_nxt = leds;
        tick_nxt = 1'b0;

        wrap_c = (pcnt == PMAX);
        adv_c  = (run && wrap_c) || (!run && step);

        if (run) begin
            pcnt_nxt = wrap_c ? '0 : pcnt + PW'(1);
        end

        if (mode_load) begin
            // A load always restarts the mode and discards any coincident advance.
            mode_nxt = mode_t'(mode_sel);
            pcnt_nxt = '0;
            dir_nxt  = UP;
            leds_nxt = init_leds(mode_t'(mode_sel));
        end else if (adv_c) begin
            tick_nxt = 1'b1;
            unique case (mode_q)
                M_WALK: begin
                    if (!$onehot(leds)) begin
                        leds_nxt = 4'b0001;
                        dir_nxt  = UP;
                    end else begin
                        leds_nxt = {leds[2:0], leds[3]};
                    end
                end
                M_BOUNCE: begin
                    if (!$onehot(leds)) begin
                        leds_nxt = 4'b0001;
                        dir_nxt  = UP;
                    end else if (dir_q == UP) begin
                        // Ends turn around so neither end value repeats.
                        if (leds == 4'b1000) begin
                            leds_nxt = 4'b0100;
                            dir_nxt  = DOWN;
                        end else begin
                            leds_nxt = leds << 1;
                            if (leds == 4'b0100) dir_nxt = DOWN;
                        end
                    end else begin
                        if (leds == 4'b0001) begin
                            leds_nxt = 4'b0010;
                            dir_nxt  = UP;
                        end else begin
                            leds_nxt = leds >> 1;
                            if (leds == 4'b0010) dir_nxt = UP;
                        end
                    end
                end
                M_COUNT: begin
                    leds_nxt = leds + 4'd1;
                end
                M_BLINK: begin
                    leds_nxt = (leds == 4'b1111) ? 4'b0000 : 4'b1111;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mode_q <= M_WALK;
            dir_q  <= UP;
            pcnt   <= '0;
            leds   <= 4'b0001;
            tick   <= 1'b0;
        end else begin
            mode_q <= mode_nxt;
            dir_q  <= dir_nxt;
            pcnt   <= pcnt_nxt;
            leds   <= leds_nxt;
            tick   <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed self-checking bench for led_seq_ctrl (DIV=4).
module tb_led_seq_ctrl;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] mode_sel = 2'd0;
    logic       mode_load = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [3:0] leds;
    logic       tick;
    logic [1:0] mode;

    int n_cmp = 0;
    int n_err = 0;

    led_seq_ctrl #(.DIV(DIV)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .mode_sel (mode_sel),
        .mode_load(mode_load),
        .run      (run),
        .step     (step),
        .leds     (leds),
        .tick     (tick),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reset with coincident load/step must be ignored.
    task automatic test_reset();
        rstn = 1'b0; run = 1'b0; step = 1'b1; mode_load = 1'b1; mode_sel = 2'd2;
        cyc(); cyc();
        n_cmp++; if (leds !== 4'b0001) begin n_err++; $display("FAIL reset_leds got=%b exp=0001", leds); end
        n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=0", tick); end
        n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        step = 1'b0; mode_load = 1'b0; mode_sel = 2'd0;
    endtask

    // Walk free-running from reset release.
    task automatic test_walk();
        logic [3:0] e;
        logic       et;
        e = 4'b0001;
        rstn = 1'b1; run = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            et = ((c % 4) == 0);
            if (et) e = {e[2:0], e[3]};
            n_cmp++; if (tick !== et) begin n_err++; $display("FAIL walk_tick c=%0d got=%b exp=%b", c, tick, et); end
            n_cmp++; if (leds !== e) begin n_err++; $display("FAIL walk_leds c=%0d got=%b exp=%b", c, leds, e); end
        end
        n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL walk_mode got=%0d exp=0", mode); end
        run = 1'b0;
    endtask

    // Bounce free-running across both turnarounds.
    task automatic test_bounce();
        logic [3:0] bseq [8];
        logic [3:0] e;
        logic       et;
        int         idx;
        bseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
        mode_sel = 2'd1; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        n_cmp++; if (leds !== 4'b0001) begin n_err++; $display("FAIL bounce_init_leds got=%b exp=0001", leds); end
        n_cmp++; if (mode !== 2'd1) begin n_err++; $display("FAIL bounce_mode got=%0d exp=1", mode); end
        n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL bounce_init_tick got=%b exp=0", tick); end
        e = 4'b0001; idx = 0;
        run = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            cyc();
            et = ((c % 4) == 0);
            if (et) begin e = bseq[idx]; idx++; end
            n_cmp++; if (tick !== et) begin n_err++; $display("FAIL bounce_tick c=%0d got=%b exp=%b", c, tick, et); end
            n_cmp++; if (leds !== e) begin n_err++; $display("FAIL bounce_leds c=%0d got=%b exp=%b", c, leds, e); end
        end
        run = 1'b0;
    endtask

    // Count single-stepped while paused, wrap included; prescaler left untouched.
    task automatic test_count();
        logic [3:0] e;
        int         nt;
        nt = 0;
        mode_sel = 2'd2; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        n_cmp++; if (leds !== 4'b0000) begin n_err++; $display("FAIL count_init_leds got=%b exp=0000", leds); end
        n_cmp++; if (mode !== 2'd2) begin n_err++; $display("FAIL count_mode got=%0d exp=2", mode); end
        for (int i = 0; i < 17; i++) begin
            e = 4'(i + 1);
            step = 1'b1;
            cyc();
            step = 1'b0;
            if (tick === 1'b1) nt++;
            n_cmp++; if (leds !== e) begin n_err++; $display("FAIL count_leds i=%0d got=%b exp=%b", i, leds, e); end
            for (int k = 0; k < 2; k++) begin
                cyc();
                if (tick === 1'b1) nt++;
                n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL count_tick_width i=%0d got=%b exp=0", i, tick); end
            end
        end
        n_cmp++; if (nt != 17) begin n_err++; $display("FAIL count_ticks got=%0d exp=17", nt); end
        // Prescaler still at 0: first running advance is 4 cycles out; step is ignored while running.
        run = 1'b1; step = 1'b1;
        cyc();
        step = 1'b0;
        n_cmp++; if (leds !== 4'b0001 || tick !== 1'b0) begin n_err++; $display("FAIL count_step_in_run got=%b/%b exp=0001/0", leds, tick); end
        cyc(); cyc();
        n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL count_run_early got=%b exp=0", tick); end
        cyc();
        n_cmp++; if (tick !== 1'b1 || leds !== 4'b0010) begin n_err++; $display("FAIL count_run_adv got=%b/%b exp=0010/1", leds, tick); end
        run = 1'b0;
    endtask

    // Blink with a pause at pcnt=2; resume preserves the prescaler phase.
    task automatic test_blink_pause();
        mode_sel = 2'd3; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        n_cmp++; if (leds !== 4'b1111 || mode !== 2'd3) begin n_err++; $display("FAIL blink_init got=%b/%0d exp=1111/3", leds, mode); end
        run = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            n_cmp++; if (tick !== (c == 4)) begin n_err++; $display("FAIL blink_tick c=%0d got=%b", c, tick); end
        end
        n_cmp++; if (leds !== 4'b0000) begin n_err++; $display("FAIL blink_toggle got=%b exp=0000", leds); end
        run = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            n_cmp++; if (tick !== 1'b0 || leds !== 4'b0000) begin n_err++; $display("FAIL blink_paused c=%0d got=%b/%b exp=0000/0", c, leds, tick); end
        end
        run = 1'b1;
        cyc();
        n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL blink_resume_early got=%b exp=0", tick); end
        cyc();
        n_cmp++; if (tick !== 1'b1 || leds !== 4'b1111) begin n_err++; $display("FAIL blink_resume_adv got=%b/%b exp=1111/1", leds, tick); end
    endtask

    // mode_load in the same cycle as a running advance wins.
    task automatic test_load_vs_adv();
        cyc(); cyc(); cyc();
        n_cmp++; if (tick !== 1'b0 || leds !== 4'b1111) begin n_err++; $display("FAIL lva_pre got=%b/%b exp=1111/0", leds, tick); end
        mode_sel = 2'd3; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        n_cmp++; if (leds !== 4'b1111 || tick !== 1'b0 || mode !== 2'd3) begin n_err++; $display("FAIL lva_load got=%b/%b/%0d exp=1111/0/3", leds, tick, mode); end
        for (int c = 1; c <= 4; c++) begin
            cyc();
            n_cmp++; if (tick !== (c == 4) || leds !== ((c == 4) ? 4'b0000 : 4'b1111)) begin
                n_err++; $display("FAIL lva_after c=%0d got=%b/%b", c, leds, tick);
            end
        end
        run = 1'b0;
    endtask

    // Reset mid-bounce (dir DOWN, leds 0100) restores walk from 0001.
    task automatic test_reset_mid();
        logic [3:0] bs [4];
        logic [3:0] ws [4];
        bs = '{4'b0010, 4'b0100, 4'b1000, 4'b0100};
        ws = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        mode_sel = 2'd1; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step = 1'b1; cyc(); step = 1'b0;
            n_cmp++; if (leds !== bs[i] || tick !== 1'b1) begin n_err++; $display("FAIL rmid_bounce i=%0d got=%b/%b exp=%b/1", i, leds, tick, bs[i]); end
            cyc();
        end
        rstn = 1'b0; step = 1'b1;
        cyc();
        rstn = 1'b1; step = 1'b0;
        n_cmp++; if (mode !== 2'd0 || leds !== 4'b0001 || tick !== 1'b0) begin n_err++; $display("FAIL rmid_reset got=%0d/%b/%b exp=0/0001/0", mode, leds, tick); end
        for (int i = 0; i < 4; i++) begin
            step = 1'b1; cyc(); step = 1'b0;
            n_cmp++; if (leds !== ws[i] || tick !== 1'b1) begin n_err++; $display("FAIL rmid_walk i=%0d got=%b/%b exp=%b/1", i, leds, tick, ws[i]); end
            cyc();
        end
        run = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            n_cmp++; if (tick !== (c == 4)) begin n_err++; $display("FAIL rmid_first_adv c=%0d got=%b", c, tick); end
        end
        n_cmp++; if (leds !== 4'b0010) begin n_err++; $display("FAIL rmid_first_leds got=%b exp=0010", leds); end
        run = 1'b0;
    endtask

    // Reloading the active mode still restarts it.
    task automatic test_same_mode_reload();
        mode_sel = 2'd0; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        n_cmp++; if (leds !== 4'b0001 || tick !== 1'b0 || mode !== 2'd0) begin n_err++; $display("FAIL reload_same got=%b/%b/%0d exp=0001/0/0", leds, tick, mode); end
    endtask

    initial begin
        #2;
        test_reset();
        test_walk();
        test_bounce();
        test_count();
        test_blink_pause();
        test_load_vs_adv();
        test_reset_mid();
        test_same_mode_reload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
